// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sample source.
// FIR_SRC_FLUSH_EN adds the FLUSH state that feeds TAPS trailing zeros per frame.
package fir_pkg;

  localparam int unsigned FIR_TAPS   = 8;
  localparam int unsigned FIR_DATA_W = 8;

`ifdef FIR_SRC_FLUSH_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } src_state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1
  } src_state_e;
`endif

endpackage

// File: rtl/fir_src_fifo.sv
// Circular FIFO holding {last, data} entries; DEPTH must be a power of two.
// The caller guarantees push only when not full and pop only when not empty.
module fir_src_fifo #(
  parameter  int unsigned WIDTH = 9,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head_c,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head_c = mem[rd_ptr];
  assign level  = level_q;

endmodule

// File: rtl/fir_sample_source.sv
// Buffers frame samples and presents one per tick to an 8-tap FIR.
// FIR_SRC_FLUSH_EN: after each frame's last sample, feed TAPS zeros before frame_done.
module fir_sample_source
  import fir_pkg::*;
#(
  parameter  int unsigned DATA_W = FIR_DATA_W,
  parameter  int unsigned DEPTH  = 8,
  parameter  int unsigned TAPS   = FIR_TAPS,
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              tick,
  output logic [DATA_W-1:0] x,
  output logic              x_valid,
  output logic [LVL_W-1:0]  level,
  output logic              busy,
  output logic              underrun,
  output logic              frame_done
);

  src_state_e        state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              x_valid_q, x_valid_d;
  logic              underrun_q, underrun_d;
  logic              frame_done_q, frame_done_d;
  logic              push_c, pop_c;
  logic [DATA_W:0]   head_c;
  logic [LVL_W-1:0]  fifo_level;

`ifdef FIR_SRC_FLUSH_EN
  localparam int unsigned CNT_W = $clog2(TAPS) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign in_ready = (fifo_level < LVL_W'(DEPTH)) && (state_q != FLUSH);
`else
  assign in_ready = fifo_level < LVL_W'(DEPTH);
`endif

  assign push_c = in_valid && in_ready;

  fir_src_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (push_c),
    .pop    (pop_c),
    .wdata  ({in_last, in_data}),
    .head_c (head_c),
    .level  (fifo_level)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      x_valid_q    <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef FIR_SRC_FLUSH_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      x_valid_q    <= x_valid_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
`ifdef FIR_SRC_FLUSH_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // Pop decision uses the registered (pre-push) level, so a same-cycle push is never bypassed.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    x_valid_d    = x_valid_q;
    underrun_d   = underrun_q;
    frame_done_d = 1'b0;
    pop_c        = 1'b0;
`ifdef FIR_SRC_FLUSH_EN
    cnt_d        = cnt_q;
`endif
    if (tick) begin
      case (state_q)
        IDLE, STREAM: begin
          if (fifo_level != '0) begin
            pop_c     = 1'b1;
            x_d       = head_c[DATA_W-1:0];
            x_valid_d = 1'b1;
            state_d   = STREAM;
            if (head_c[DATA_W]) begin
`ifdef FIR_SRC_FLUSH_EN
              state_d = FLUSH;
              cnt_d   = '0;
`else
              state_d      = IDLE;
              frame_done_d = 1'b1;
`endif
            end
          end else begin
            x_d       = '0;
            x_valid_d = 1'b0;
            if (state_q == STREAM) underrun_d = 1'b1;
          end
        end
`ifdef FIR_SRC_FLUSH_EN
        FLUSH: begin
          x_d       = '0;
          x_valid_d = 1'b1;
          if (cnt_q == CNT_W'(TAPS - 1)) begin
            cnt_d        = '0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign level      = fifo_level;
  assign busy       = state_q != IDLE;
  assign underrun   = underrun_q;
  assign frame_done = frame_done_q;

endmodule
